// File: rtl/cache_def.sv
// Shared L1/victim-cache definitions: default geometry, the evict transfer
// to the victim cache, the swap-controller states and the VC probe result.
package cache_def;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_LINE_W = 128;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_LINE_W-1:0] data;
  } evict_data_type;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    FILL,
    EVICT,
    RESP
  } vc_swap_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    hit;
    logic                    dirty;
    logic [CACHE_LINE_W-1:0] data;
  } vc_probe_res_type;

endpackage

// File: rtl/d_vc_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module d_vc_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/d_vc_swap_ctrl.sv
// L1 D-cache miss handler for the victim cache: probe the VC, swap on a hit or
// fill from memory on a miss, push the L1 victim into the VC, answer the L1.
module d_vc_swap_ctrl
  import cache_def::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int LINE_W = CACHE_LINE_W,
  parameter int OFFS_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              vict_valid_i,
  input  logic              vict_dirty_i,
  input  logic [ADDR_W-1:0] vict_addr_i,
  input  logic [LINE_W-1:0] vict_data_i,
  output logic              vc_req_valid_o,
  output logic [ADDR_W-1:0] vc_req_addr_o,
  input  logic              vc_res_valid_i,
  input  logic              vc_hit_i,
  input  logic              vc_res_dirty_i,
  input  logic [LINE_W-1:0] vc_res_data_i,
  output evict_data_type    evict_o,
  input  logic              evict_ready_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              res_valid_o,
  output logic [LINE_W-1:0] res_data_o,
  output logic              res_dirty_o,
  output logic              res_from_vc_o,
  output logic [31:0]       probe_cnt_o,
  output logic [31:0]       vc_hit_cnt_o
);

  vc_swap_state_e   state_q, state_d;
  vc_probe_res_type probe_res;

  logic              accept;
  logic [ADDR_W-1:0] miss_line_q;
  logic              vict_dirty_q;
  logic [ADDR_W-1:0] vict_addr_q;
  logic [LINE_W-1:0] vict_data_q;
  logic              evict_en_q;
  logic [LINE_W-1:0] res_data_q;
  logic              res_dirty_q;
  logic              res_from_vc_q;
  logic              unused_offs;

  assign probe_res   = '{valid: vc_res_valid_i, hit: vc_hit_i,
                         dirty: vc_res_dirty_i, data: vc_res_data_i};
  assign accept      = (state_q == IDLE) && miss_valid_i;
  assign unused_offs = ^miss_addr_i[OFFS_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid_i) state_d = PROBE;
      PROBE:   if (probe_res.valid) state_d = probe_res.hit ? EVICT : FILL;
      FILL:    if (mem_ready_i) state_d = EVICT;
      EVICT:   if (!evict_en_q || evict_ready_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All valids decode from the state register alone, so no input reaches them.
  always_comb begin
    miss_ready_o    = (state_q == IDLE);
    vc_req_valid_o  = (state_q == PROBE);
    mem_req_valid_o = (state_q == FILL);
    res_valid_o     = (state_q == RESP);
    evict_o         = '{valid: (state_q == EVICT) && evict_en_q, dirty: vict_dirty_q,
                        addr: vict_addr_q, data: vict_data_q};
  end

  // Eviction is skipped when there is no victim or when the victim aliases the
  // missing line, which would otherwise plant a stale copy in the VC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_line_q   <= '0;
      vict_dirty_q  <= 1'b0;
      vict_addr_q   <= '0;
      vict_data_q   <= '0;
      evict_en_q    <= 1'b0;
      res_data_q    <= '0;
      res_dirty_q   <= 1'b0;
      res_from_vc_q <= 1'b0;
    end else begin
      if (accept) begin
        miss_line_q  <= {miss_addr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
        vict_dirty_q <= vict_dirty_i;
        vict_addr_q  <= vict_addr_i;
        vict_data_q  <= vict_data_i;
        evict_en_q   <= vict_valid_i &&
                        (vict_addr_i[ADDR_W-1:OFFS_W] != miss_addr_i[ADDR_W-1:OFFS_W]);
      end
      if ((state_q == PROBE) && probe_res.valid) begin
        res_data_q    <= probe_res.data;
        res_dirty_q   <= probe_res.dirty;
        res_from_vc_q <= probe_res.hit;
      end
      if ((state_q == FILL) && mem_ready_i) begin
        res_data_q    <= mem_data_i;
        res_dirty_q   <= 1'b0;
        res_from_vc_q <= 1'b0;
      end
    end
  end

  assign vc_req_addr_o  = miss_line_q;
  assign mem_req_addr_o = miss_line_q;
  assign res_data_o     = res_data_q;
  assign res_dirty_o    = res_dirty_q;
  assign res_from_vc_o  = res_from_vc_q;

  d_vc_sat_counter #(.CNT_W(32)) u_probe_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (accept),
    .cnt_o  (probe_cnt_o)
  );

  d_vc_sat_counter #(.CNT_W(32)) u_hit_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  ((state_q == PROBE) && probe_res.valid && probe_res.hit),
    .cnt_o  (vc_hit_cnt_o)
  );

endmodule

// File: tb/tb_d_vc_swap_ctrl.sv
// Directed bench for d_vc_swap_ctrl: hit/miss swaps, backpressure, guards,
// counter saturation and asynchronous reset.
module tb_d_vc_swap_ctrl;
  import cache_def::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic         vict_valid_i;
  logic         vict_dirty_i;
  logic [31:0]  vict_addr_i;
  logic [127:0] vict_data_i;
  logic         vc_req_valid_o;
  logic [31:0]  vc_req_addr_o;
  logic         vc_res_valid_i;
  logic         vc_hit_i;
  logic         vc_res_dirty_i;
  logic [127:0] vc_res_data_i;
  evict_data_type evict_o;
  logic         evict_ready_i;
  logic         mem_req_valid_o;
  logic [31:0]  mem_req_addr_o;
  logic         mem_ready_i;
  logic [127:0] mem_data_i;
  logic         res_valid_o;
  logic [127:0] res_data_o;
  logic         res_dirty_o;
  logic         res_from_vc_o;
  logic [31:0]  probe_cnt_o;
  logic [31:0]  vc_hit_cnt_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  d_vc_swap_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .vict_valid_i(vict_valid_i), .vict_dirty_i(vict_dirty_i),
    .vict_addr_i(vict_addr_i), .vict_data_i(vict_data_i),
    .vc_req_valid_o(vc_req_valid_o), .vc_req_addr_o(vc_req_addr_o),
    .vc_res_valid_i(vc_res_valid_i), .vc_hit_i(vc_hit_i),
    .vc_res_dirty_i(vc_res_dirty_i), .vc_res_data_i(vc_res_data_i),
    .evict_o(evict_o), .evict_ready_i(evict_ready_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_dirty_o(res_dirty_o),
    .res_from_vc_o(res_from_vc_o), .probe_cnt_o(probe_cnt_o), .vc_hit_cnt_o(vc_hit_cnt_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog_timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // Drives one miss for the accept edge, then scrambles the request inputs so
  // any late sampling by the DUT shows up. Returns in the first PROBE cycle.
  task automatic accept(input logic [31:0] maddr, input logic vv, input logic vd,
                        input logic [31:0] vaddr, input logic [127:0] vdata);
    miss_valid_i = 1'b1; miss_addr_i = maddr;
    vict_valid_i = vv; vict_dirty_i = vd; vict_addr_i = vaddr; vict_data_i = vdata;
    @(negedge clk_i);
    miss_valid_i = 1'b0; miss_addr_i = 32'hFFFF_FFFF;
    vict_valid_i = ~vv; vict_dirty_i = ~vd; vict_addr_i = 32'hDEAD_0000; vict_data_i = ~vdata;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    miss_valid_i = 0; miss_addr_i = 0; vict_valid_i = 0; vict_dirty_i = 0;
    vict_addr_i = 0; vict_data_i = 0; vc_res_valid_i = 0; vc_hit_i = 0;
    vc_res_dirty_i = 0; vc_res_data_i = 0; evict_ready_i = 0; mem_ready_i = 0; mem_data_i = 0;
    repeat (3) @(negedge clk_i);
    total++; if ({vc_req_valid_o, mem_req_valid_o, evict_o.valid, res_valid_o} !== 4'b0)
      $display("FAIL reset_valids got %b exp 0000", {vc_req_valid_o, mem_req_valid_o, evict_o.valid, res_valid_o}); else passed++;
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== 64'd0)
      $display("FAIL reset_counters got %h/%h exp 0/0", probe_cnt_o, vc_hit_cnt_o); else passed++;
    total++; if ({vc_req_addr_o, res_data_o, evict_o.addr} !== 192'd0)
      $display("FAIL reset_data got %h %h %h exp 0", vc_req_addr_o, res_data_o, evict_o.addr); else passed++;
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++; if (miss_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", miss_ready_o); else passed++;
  endtask

  task automatic test_hit_dirty();
    vc_res_valid_i = 1; vc_hit_i = 1; vc_res_dirty_i = 1; vc_res_data_i = {32{4'h1}}; evict_ready_i = 1;
    accept(32'h0000_1234, 1'b1, 1'b1, 32'h0000_5670, {16{8'hA5}});
    total++; if ({vc_req_valid_o, miss_ready_o} !== 2'b10)
      $display("FAIL hit_probe_valid_ready got %b exp 10", {vc_req_valid_o, miss_ready_o}); else passed++;
    total++; if (vc_req_addr_o !== 32'h0000_1230) $display("FAIL hit_probe_addr got %h exp 00001230", vc_req_addr_o); else passed++;
    total++; if (probe_cnt_o !== 32'd1) $display("FAIL hit_probe_cnt got %0d exp 1", probe_cnt_o); else passed++;
    @(negedge clk_i);
    vc_res_valid_i = 0;
    total++; if ({evict_o.valid, evict_o.dirty, evict_o.addr} !== {2'b11, 32'h0000_5670})
      $display("FAIL hit_evict got v=%b d=%b a=%h exp v=1 d=1 a=00005670", evict_o.valid, evict_o.dirty, evict_o.addr); else passed++;
    total++; if (evict_o.data !== {16{8'hA5}}) $display("FAIL hit_evict_data got %h exp a5..", evict_o.data); else passed++;
    total++; if (vc_hit_cnt_o !== 32'd1) $display("FAIL hit_cnt got %0d exp 1", vc_hit_cnt_o); else passed++;
    @(negedge clk_i);
    total++; if ({res_valid_o, res_dirty_o, res_from_vc_o, evict_o.valid} !== 4'b1110)
      $display("FAIL hit_resp_flags got %b exp 1110", {res_valid_o, res_dirty_o, res_from_vc_o, evict_o.valid}); else passed++;
    total++; if (res_data_o !== {32{4'h1}}) $display("FAIL hit_resp_data got %h exp 1111..", res_data_o); else passed++;
    @(negedge clk_i);
    total++; if ({res_valid_o, miss_ready_o} !== 2'b01)
      $display("FAIL hit_resp_one_cycle got %b exp 01", {res_valid_o, miss_ready_o}); else passed++;
  endtask

  task automatic test_miss_no_victim();
    int bad = 0;
    vc_res_valid_i = 1; vc_hit_i = 0; vc_res_dirty_i = 1; vc_res_data_i = {32{4'h9}}; evict_ready_i = 1;
    accept(32'h0000_2238, 1'b0, 1'b1, 32'h0000_9990, {16{8'h5A}});
    @(negedge clk_i);
    vc_res_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h0000_2230 || evict_o.valid !== 1'b0) bad++;
      if (i == 4) begin mem_ready_i = 1; mem_data_i = {32{4'h2}}; end
      @(negedge clk_i);
    end
    mem_ready_i = 0;
    total++; if (bad != 0) $display("FAIL miss_mem_req_hold got %0d bad cycles exp 0", bad); else passed++;
    total++; if ({mem_req_valid_o, evict_o.valid, res_valid_o} !== 3'b000)
      $display("FAIL miss_evict_state got %b exp 000", {mem_req_valid_o, evict_o.valid, res_valid_o}); else passed++;
    @(negedge clk_i);
    total++; if ({res_valid_o, res_dirty_o, res_from_vc_o, evict_o.valid} !== 4'b1000)
      $display("FAIL miss_resp_flags got %b exp 1000", {res_valid_o, res_dirty_o, res_from_vc_o, evict_o.valid}); else passed++;
    total++; if (res_data_o !== {32{4'h2}}) $display("FAIL miss_resp_data got %h exp 2222..", res_data_o); else passed++;
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== {32'd2, 32'd1})
      $display("FAIL miss_counters got %0d/%0d exp 2/1", probe_cnt_o, vc_hit_cnt_o); else passed++;
    @(negedge clk_i);
  endtask

  task automatic test_ignored_inputs();
    vc_res_valid_i = 1; vc_hit_i = 1; mem_ready_i = 1;
    repeat (2) @(negedge clk_i);
    total++; if ({miss_ready_o, vc_req_valid_o, mem_req_valid_o, res_valid_o} !== 4'b1000)
      $display("FAIL idle_ignore_state got %b exp 1000", {miss_ready_o, vc_req_valid_o, mem_req_valid_o, res_valid_o}); else passed++;
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== {32'd2, 32'd1})
      $display("FAIL idle_ignore_counters got %0d/%0d exp 2/1", probe_cnt_o, vc_hit_cnt_o); else passed++;
    vc_res_valid_i = 0; vc_hit_i = 0; mem_ready_i = 0;
  endtask

  task automatic test_evict_backpressure();
    int moved = 0, early = 0;
    vc_res_valid_i = 1; vc_hit_i = 1; vc_res_dirty_i = 0; vc_res_data_i = {32{4'h3}}; evict_ready_i = 0;
    accept(32'h0000_3000, 1'b1, 1'b0, 32'h0000_4440, {4{32'hDEAD_BEEF}});
    @(negedge clk_i);
    vc_res_valid_i = 0;
    miss_valid_i = 1; miss_addr_i = 32'h0000_7000;
    for (int i = 0; i < 10; i++) begin
      if ({evict_o.valid, evict_o.dirty, evict_o.addr} !== {2'b10, 32'h0000_4440} ||
          evict_o.data !== {4{32'hDEAD_BEEF}}) moved++;
      if (res_valid_o !== 1'b0 || miss_ready_o !== 1'b0) early++;
      @(negedge clk_i);
    end
    total++; if (moved != 0) $display("FAIL bp_evict_stable got %0d bad cycles exp 0", moved); else passed++;
    total++; if (early != 0) $display("FAIL bp_no_early_resp got %0d bad cycles exp 0", early); else passed++;
    evict_ready_i = 1;
    @(negedge clk_i);
    miss_valid_i = 0;
    total++; if ({res_valid_o, res_dirty_o, res_from_vc_o} !== 3'b101 || res_data_o !== {32{4'h3}})
      $display("FAIL bp_resp got %b %h exp 101 3333..", {res_valid_o, res_dirty_o, res_from_vc_o}, res_data_o); else passed++;
    @(negedge clk_i);
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== {32'd3, 32'd2})
      $display("FAIL bp_busy_miss_ignored got %0d/%0d exp 3/2", probe_cnt_o, vc_hit_cnt_o); else passed++;
  endtask

  task automatic test_self_evict();
    vc_res_valid_i = 1; vc_hit_i = 1; vc_res_dirty_i = 0; vc_res_data_i = {32{4'h7}}; evict_ready_i = 1;
    accept(32'h0000_7788, 1'b1, 1'b1, 32'h0000_7784, {16{8'h3C}});
    @(negedge clk_i);
    vc_res_valid_i = 0;
    total++; if (evict_o.valid !== 1'b0) $display("FAIL self_evict_suppressed got %b exp 0", evict_o.valid); else passed++;
    @(negedge clk_i);
    total++; if ({res_valid_o, res_from_vc_o} !== 2'b11 || res_data_o !== {32{4'h7}})
      $display("FAIL self_evict_resp got %b %h exp 11 7777..", {res_valid_o, res_from_vc_o}, res_data_o); else passed++;
    @(negedge clk_i);
  endtask

  task automatic test_saturation();
    force dut.u_probe_cnt.cnt_q = 32'hFFFF_FFFE;
    force dut.u_hit_cnt.cnt_q   = 32'hFFFF_FFFE;
    #1;
    release dut.u_probe_cnt.cnt_q;
    release dut.u_hit_cnt.cnt_q;
    @(negedge clk_i);
    vc_res_valid_i = 1; vc_hit_i = 1; evict_ready_i = 1;
    accept(32'h0000_A000, 1'b0, 1'b0, 32'h0, 128'h0);
    repeat (3) @(negedge clk_i);
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== {2{32'hFFFF_FFFF}})
      $display("FAIL sat_first got %h/%h exp ffffffff/ffffffff", probe_cnt_o, vc_hit_cnt_o); else passed++;
    accept(32'h0000_B000, 1'b0, 1'b0, 32'h0, 128'h0);
    repeat (3) @(negedge clk_i);
    vc_res_valid_i = 0;
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== {2{32'hFFFF_FFFF}})
      $display("FAIL sat_hold got %h/%h exp ffffffff/ffffffff", probe_cnt_o, vc_hit_cnt_o); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int stray = 0;
    vc_res_valid_i = 1; vc_hit_i = 0; evict_ready_i = 1; mem_ready_i = 0;
    accept(32'h0000_C0C4, 1'b1, 1'b1, 32'h0000_D0D0, {16{8'h66}});
    @(negedge clk_i);
    vc_res_valid_i = 0;
    total++; if (mem_req_valid_o !== 1'b1) $display("FAIL rst_fill_entered got %b exp 1", mem_req_valid_o); else passed++;
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({vc_req_valid_o, mem_req_valid_o, evict_o.valid, res_valid_o} !== 4'b0 || mem_req_addr_o !== 32'd0)
      $display("FAIL rst_async_outputs got %b %h exp 0000 0", {vc_req_valid_o, mem_req_valid_o, evict_o.valid, res_valid_o}, mem_req_addr_o); else passed++;
    total++; if ({probe_cnt_o, vc_hit_cnt_o} !== 64'd0)
      $display("FAIL rst_async_counters got %h/%h exp 0/0", probe_cnt_o, vc_hit_cnt_o); else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_ready_i = 1; mem_data_i = {32{4'hE}};
    for (int i = 0; i < 4; i++) begin
      if (evict_o.valid !== 1'b0 || res_valid_o !== 1'b0 || miss_ready_o !== 1'b1) stray++;
      @(negedge clk_i);
    end
    mem_ready_i = 0;
    total++; if (stray != 0) $display("FAIL rst_no_stray got %0d bad cycles exp 0", stray); else passed++;
  endtask

  initial begin
    test_reset();
    test_hit_dirty();
    test_miss_no_victim();
    test_ignored_inputs();
    test_evict_backpressure();
    test_self_evict();
    test_saturation();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/d_vc_swap_ctrl.md
Name: d_vc_swap_ctrl

Overview:
- L1 D-cache-side initiator for the victim-cache protocol.
- On an L1 miss it probes the victim cache (VC). On a VC hit it swaps lines; on a VC miss it fills from memory.
- In both cases it pushes the L1 victim line into the VC as an evict_data_type transfer.
- Sits between the L1 D-cache controller, d_victim_cache and the memory-side port.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits.
- OFFS_W, 4, line-offset bits; line address = addr[ADDR_W-1:OFFS_W].

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- miss_valid_i  in  1  L1 miss request.
- miss_ready_o  out  1  high only in IDLE.
- miss_addr_i  in  ADDR_W  missing address.
- vict_valid_i  in  1  L1 victim line exists.
- vict_dirty_i  in  1  victim dirty.
- vict_addr_i  in  ADDR_W  victim line address.
- vict_data_i  in  LINE_W  victim data.
- vc_req_valid_o  out  1  VC probe request.
- vc_req_addr_o  out  ADDR_W  probe address.
- vc_res_valid_i  in  1  VC probe result valid.
- vc_hit_i  in  1  VC hit.
- vc_res_dirty_i  in  1  returned line dirty.
- vc_res_data_i  in  LINE_W  returned line.
- evict_o  out  evict_data_type  victim transfer to VC (valid, dirty, addr, data).
- evict_ready_i  in  1  VC accepts evict_o this cycle.
- mem_req_valid_o  out  1  memory line-read request.
- mem_req_addr_o  out  ADDR_W  line-aligned address.
- mem_ready_i  in  1  memory data valid.
- mem_data_i  in  LINE_W  memory line.
- res_valid_o  out  1  one-cycle fill response to L1.
- res_data_o  out  LINE_W  fill data.
- res_dirty_o  out  1  fill line dirty.
- res_from_vc_o  out  1  fill came from VC.
- probe_cnt_o  out  32  VC probes issued.
- vc_hit_cnt_o  out  32  VC hits.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE.
  - All valid outputs 0; data/address outputs 0; counters 0.
  - Reset mid-operation abandons the transaction; no partial evict or response is issued after release.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i, capture miss_addr_i (offset bits zeroed) and vict_* into registers, then go to PROBE.
  - Inputs are sampled only on this accept cycle.
- PROBE:
  - vc_req_valid_o=1 and vc_req_addr_o=captured address, held until vc_res_valid_i.
  - probe_cnt_o increments once, on entry.
  - On vc_res_valid_i, latch vc_res_data_i and vc_res_dirty_i.
  - vc_hit_i=1: vc_hit_cnt_o increments, go to EVICT.
  - vc_hit_i=0: go to FILL.
  - The VC invalidates the hit entry itself (swap semantics).
- FILL:
  - mem_req_valid_o=1 with the line-aligned address, held until mem_ready_i.
  - On mem_ready_i, latch mem_data_i with dirty=0, then go to EVICT.
- EVICT:
  - If the captured vict_valid=0, go to RESP immediately; evict_o.valid stays 0.
  - Otherwise evict_o.valid=1, holding captured vict dirty/addr/data stable, until evict_ready_i; then go to RESP.
  - Eviction is issued after the probe, so the VC never matches the line just inserted.
  - If the victim line address equals the miss line address, the eviction is suppressed (protocol error guard).
- RESP:
  - res_valid_o=1 for exactly one cycle with the latched data, dirty and from_vc values; then go to IDLE.
- Latency with zero-wait responders:
  - VC hit, victim present: accept→RESP = 3 cycles.
  - VC miss: add 1 + memory wait cycles.
- Boundaries:
  - miss_valid_i while busy is ignored (ready=0).
  - vc_res_valid_i outside PROBE and mem_ready_i outside FILL are ignored.
  - evict_ready_i low indefinitely stalls in EVICT with no timeout.
  - Counters saturate at 32'hFFFF_FFFF; no wrap.
- No combinational path from any input to a valid output.

Decomposition:
- LINE_W, ADDR_W defaults and evict_data_type come from shared package cache_def.
- Add to cache_def:
  - The state enum vc_swap_state_e {IDLE, PROBE, FILL, EVICT, RESP}.
  - A vc_probe_res_type struct (valid, hit, dirty, data).
- Single FSM module; optionally factor the two saturating counters into sub-module d_vc_sat_counter.

Test Plan:
- Hit with dirty victim:
  - Stimulus: miss addr 0x0000_1234, victim addr 0x0000_5670 dirty data 0xA5…; VC hits with data 0x1111…, dirty=1; evict_ready_i=1.
  - Response: vc_req_addr_o=0x0000_1230; evict_o carries addr 0x0000_5670 dirty=1; res_valid_o one cycle with data 0x1111…, res_dirty_o=1, res_from_vc_o=1; probe_cnt=1, vc_hit_cnt=1.
- Miss, no victim:
  - Stimulus: VC miss, vict_valid_i=0, memory returns 0x2222… after 5 cycles.
  - Response: mem_req_valid_o held 5 cycles at 0x…30; evict_o.valid never 1; res_from_vc_o=0, res_dirty_o=0.
- Evict backpressure:
  - Stimulus: evict_ready_i low for 10 cycles.
  - Response: evict_o stable all 10 cycles; res_valid_o only after the handshake; miss_ready_o=0 throughout.
- Reset mid-FILL:
  - Stimulus: rst_ni=0 during FILL.
  - Response: all outputs 0 immediately; after release miss_ready_o=1; no evict or response issued.
- Saturation:
  - Stimulus: force both counters to 32'hFFFF_FFFE, run two VC-hit transactions.
  - Response: both counters read 32'hFFFF_FFFF.
- Self-eviction guard:
  - Stimulus: victim addr equal to the miss line.
  - Response: evict_o.valid stays 0; response still delivered.
